// File: rtl/fib_arb_pkg.sv
// Shared types, constants and the winner-select function for the fibonacci arbiter.
// Optional feature macro: FIB_ARB_RR_EN (round-robin arbitration instead of fixed priority).
package fib_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } arb_state_e;

    typedef logic [15:0] u16_t;

    localparam int   NREQ_DEF = 4;
    localparam int   NREQ_MAX = 8;
    localparam u16_t FIB_F0   = 16'd0;
    localparam u16_t FIB_F1   = 16'd1;

    // Scans nreq requesters starting at index 'first', wrapping; first active one wins.
    function automatic logic [2:0] fib_arb_pick(input logic [NREQ_MAX-1:0] req,
                                                input logic [2:0]          first,
                                                input int                  nreq);
        logic [2:0] win;
        logic       found;
        int         idx;
        win   = 3'd0;
        found = 1'b0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            idx = int'(first) + i;
            if (idx >= nreq) idx = idx - nreq;
            if (i < nreq && !found && req[idx[2:0]]) begin
                win   = idx[2:0];
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/fib_arbiter_fibonacci.sv
// Iterative Fibonacci engine: one iteration per cycle after start, done strobes with F(din).
// Always restarts from F0/F1 with iteration count 1; din = 0 is reported as F0.
module fib_arbiter_fibonacci
    import fib_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  u16_t din,
    output logic done,
    output u16_t dout
);

    u16_t f0_q, f1_q, cnt_q, tgt_q;
    logic run_q, zero_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f0_q   <= FIB_F0;
            f1_q   <= FIB_F1;
            cnt_q  <= 16'd1;
            tgt_q  <= 16'd1;
            run_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (start) begin
            f0_q   <= FIB_F0;
            f1_q   <= FIB_F1;
            cnt_q  <= 16'd1;
            tgt_q  <= (din == 16'd0) ? 16'd1 : din;
            zero_q <= (din == 16'd0);
            run_q  <= 1'b1;
        end else if (run_q) begin
            if (done) begin
                run_q <= 1'b0;
            end else begin
                f0_q  <= f1_q;
                f1_q  <= f0_q + f1_q;
                cnt_q <= cnt_q + 16'd1;
            end
        end
    end

    // f1_q holds F(cnt_q); results wrap naturally at 16 bits.
    assign done = run_q && (cnt_q == tgt_q);
    assign dout = zero_q ? FIB_F0 : f1_q;

endmodule

// File: rtl/fib_arbiter.sv
// Shares one Fibonacci engine among NREQ requesters, one job at a time, no queuing.
// FIB_ARB_RR_EN selects round-robin arbitration; otherwise lowest index wins.
module fib_arbiter
    import fib_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0][15:0] din,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    output logic [IDW-1:0]        rsp_id,
    output logic [15:0]           rsp_dout,
    output logic                  busy
);

    arb_state_e          state_q, state_d;
    logic [IDW-1:0]      win_q, win_d;
    u16_t                job_q, job_d;
    logic [NREQ-1:0]     gnt_q, gnt_d;
    logic                clr_q, clr_d;
    logic                start_q, start_d;
    logic                vld_q, vld_d;
    logic [IDW-1:0]      id_q, id_d;
    u16_t                dout_q, dout_d;

    logic [NREQ_MAX-1:0] req_ext;
    logic [2:0]          first;
    logic [2:0]          pick;
    logic [IDW-1:0]      pick_id;
    logic                eng_rst, eng_done;
    u16_t                eng_dout;

`ifdef FIB_ARB_RR_EN
    logic [2:0] ptr_q, ptr_d;
    assign first = ptr_q;
`else
    assign first = 3'd0;
`endif

    always_comb begin
        req_ext           = '0;
        req_ext[NREQ-1:0] = req;
    end

    assign pick    = fib_arb_pick(req_ext, first, NREQ);
    assign pick_id = IDW'(pick);

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        job_d   = job_q;
        gnt_d   = '0;
        clr_d   = 1'b0;
        start_d = 1'b0;
        vld_d   = 1'b0;
        id_d    = id_q;
        dout_d  = dout_q;
`ifdef FIB_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    win_d          = pick_id;
                    job_d          = din[pick_id];
                    gnt_d[pick_id] = 1'b1;
                    clr_d          = 1'b1;
                    state_d        = S_CLEAR;
`ifdef FIB_ARB_RR_EN
                    ptr_d = (int'(pick) == NREQ - 1) ? 3'd0 : pick + 3'd1;
`endif
                end
            end
            S_CLEAR: begin
                start_d = 1'b1;
                state_d = S_LAUNCH;
            end
            S_LAUNCH: state_d = S_WAIT;
            S_WAIT: begin
                if (eng_done) begin
                    dout_d  = eng_dout;
                    id_d    = win_q;
                    vld_d   = 1'b1;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            win_q   <= '0;
            job_q   <= '0;
            gnt_q   <= '0;
            clr_q   <= 1'b0;
            start_q <= 1'b0;
            vld_q   <= 1'b0;
            id_q    <= '0;
            dout_q  <= '0;
`ifdef FIB_ARB_RR_EN
            ptr_q   <= 3'd0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            job_q   <= job_d;
            gnt_q   <= gnt_d;
            clr_q   <= clr_d;
            start_q <= start_d;
            vld_q   <= vld_d;
            id_q    <= id_d;
            dout_q  <= dout_d;
`ifdef FIB_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Engine is cleared by the CLEAR pulse so every job starts from F0/F1.
    assign eng_rst = ~reset_n | clr_q;

    fib_arbiter_fibonacci u_fib (
        .clk   (clk),
        .rst   (eng_rst),
        .start (start_q),
        .din   (job_q),
        .done  (eng_done),
        .dout  (eng_dout)
    );

    assign gnt       = gnt_q;
    assign rsp_valid = vld_q;
    assign rsp_id    = id_q;
    assign rsp_dout  = dout_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_fib_arbiter.sv
// Randomized and directed bench for fib_arbiter against a rule-level model.
// Honors FIB_ARB_RR_EN when building the expected grant order.
module tb_fib_arbiter;

    localparam int NREQ = 4;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req;
    logic [NREQ-1:0][15:0] din;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic [1:0]            rsp_id;
    logic [15:0]           rsp_dout;
    logic                  busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_w  = NREQ - 1;

    fib_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .din       (din),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_dout  (rsp_dout),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned fib_ref(input int n);
        int unsigned a = 0, b = 1, t;
        for (int i = 0; i < n; i++) begin
            t = (a + b) % 65536;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int pick_model(input logic [NREQ-1:0] r);
`ifdef FIB_ARB_RR_EN
        for (int k = 1; k <= NREQ; k++)
            if (r[(last_w + k) % NREQ]) return (last_w + k) % NREQ;
`else
        for (int k = 0; k < NREQ; k++)
            if (r[k]) return k;
`endif
        return 0;
    endfunction

    // Called at a negedge of an IDLE cycle; returns at the negedge of the next IDLE cycle.
    task automatic run_job(input logic [NREQ-1:0] r, input logic [NREQ-1:0][15:0] d,
                           input bit hold, input string tag);
        int c0, w, n, extra;
        bit seen;
        req = r;
        din = d;
        c0  = cyc;
        w   = pick_model(r);
        n   = int'(d[w]);
        @(negedge clk);
        chk({tag, ".gnt"}, 32'(gnt), 32'(1 << w));
        chk({tag, ".busy"}, 32'(busy), 32'd1);
        if (!hold) begin
            req = '0;
            for (int k = 0; k < NREQ; k++) din[k] = 16'($urandom);
        end
        seen  = 1'b0;
        extra = 0;
        repeat (n + 20) begin
            @(negedge clk);
            if (gnt != '0) extra++;
            if (rsp_valid) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, ".seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({tag, ".lat"}, 32'(cyc - c0), 32'(3 + ((n == 0) ? 1 : n)));
            chk({tag, ".id"}, 32'(rsp_id), 32'(w));
            chk({tag, ".dout"}, 32'(rsp_dout), fib_ref(n));
            chk({tag, ".xgnt"}, 32'(extra), 32'd0);
            last_w = w;
            @(negedge clk);
            chk({tag, ".vld_off"}, 32'(rsp_valid), 32'd0);
            chk({tag, ".idle"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        logic [NREQ-1:0][15:0] d;
        int bnd[5];
        int hits;
        bnd = '{0, 1, 2, 24, 25};
        reset_n = 1'b0;
        req     = '0;
        din     = '0;
        repeat (3) @(negedge clk);
        chk("rst.gnt", 32'(gnt), 32'd0);
        chk("rst.vld", 32'(rsp_valid), 32'd0);
        chk("rst.id", 32'(rsp_id), 32'd0);
        chk("rst.dout", 32'(rsp_dout), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        reset_n = 1'b1;

        d = '0;
        d[2] = 16'd5;
        run_job(4'b0100, d, 1'b0, "single");
        chk("single.val5", 32'(rsp_dout), 32'd5);

        foreach (bnd[i]) begin
            d = '0;
            d[1] = 16'(bnd[i]);
            run_job(4'b0010, d, 1'b0, $sformatf("bnd%0d", bnd[i]));
        end
        chk("bnd25.const", 32'(rsp_dout), 32'd9489);

        d = '0;
        d[3] = 16'd10;
        run_job(4'b1000, d, 1'b0, "b2b_a");
        chk("b2b_a.const", 32'(rsp_dout), 32'd55);
        d[3] = 16'd3;
        run_job(4'b1000, d, 1'b0, "b2b_b");
        chk("b2b_b.const", 32'(rsp_dout), 32'd2);

        for (int i = 0; i < NREQ; i++) d[i] = 16'(i + 3);
        for (int k = 0; k < 8; k++) run_job(4'b1111, d, 1'b1, $sformatf("cont%0d", k));

        req = 4'b0001;
        d = '0;
        d[0] = 16'd20;
        din = d;
        @(negedge clk);
        req = '0;
        repeat (6) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst.busy", 32'(busy), 32'd0);
        chk("mrst.vld", 32'(rsp_valid), 32'd0);
        chk("mrst.dout", 32'(rsp_dout), 32'd0);
        chk("mrst.id", 32'(rsp_id), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        last_w  = NREQ - 1;
        hits = 0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid) hits++;
        end
        chk("mrst.norsp", 32'(hits), 32'd0);
        d = '0;
        d[0] = 16'd6;
        run_job(4'b0001, d, 1'b0, "mrst.after");
        chk("mrst.val8", 32'(rsp_dout), 32'd8);

        for (int j = 0; j < 20; j++) begin
            logic [NREQ-1:0] r;
            r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            for (int k = 0; k < NREQ; k++) d[k] = 16'($urandom_range(0, 40));
            run_job(r, d, bit'($urandom_range(0, 1)), $sformatf("rnd%0d", j));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
